// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with a single
// carry flop. sum/c_out are registered and only change when a result completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             bit_s;
    logic             bit_co;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Written as shift/or rather than a concatenation so WIDTH=1 elaborates.
    always_comb begin
        bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
        bit_co   = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (a_sr[0] & carry);
        res_next = (res_sr >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        carry  <= c_in;
                        cnt    <= '0;
                    end
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= bit_co;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        c_out <= bit_co;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder (WIDTH=8 and WIDTH=1)
// against plain-arithmetic expectations of a+b+c_in.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    logic start1;
    logic a1;
    logic b1;
    logic c1;
    logic busy1;
    logic done1;
    logic sum1;
    logic cout1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .c_in  (c1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .c_out (cout1)
    );

    // Runs one operation on the 8-bit DUT, scrambling inputs while it is busy,
    // and reports what was observed; the calling test does the comparisons.
    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c,
                         output int lat, output logic [7:0] got_sum, output logic got_cout,
                         output logic busy_seen, output logic held, output logic done_gone);
        logic [7:0] prev_sum;
        logic       prev_cout;
        @(negedge clk);
        a = op_a; b = op_b; c_in = op_c; start = 1'b1;
        prev_sum  = sum;
        prev_cout = c_out;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        busy_seen = busy;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
        held = 1'b1;
        lat  = 0;
        while (lat < 20) begin
            if (done) break;
            if (sum !== prev_sum || c_out !== prev_cout) held = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got_sum  = sum;
        got_cout = c_out;
        @(posedge clk);
        @(negedge clk);
        done_gone = !done && !busy;
    endtask

    task automatic test_reset();
        start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, sum, c_out} !== 11'h0) begin
            miscompares++;
            $display("[TB] FAIL reset8: got busy=%b done=%b sum=%h c_out=%b expected all 0", busy, done, sum, c_out);
        end
        vectors++;
        if ({busy1, done1, sum1, cout1} !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset1: got %b expected 0000", {busy1, done1, sum1, cout1});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [3] = '{8'h0F, 8'hFF, 8'hFF};
        logic [7:0] tb [3] = '{8'h01, 8'h01, 8'hFF};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] expv;
        int lat;
        logic [7:0] gs;
        logic gc, bs, hd, dg;
        for (int i = 0; i < 3; i++) begin
            expv = 9'(ta[i]) + 9'(tb[i]) + 9'(tc[i]);
            do_op(ta[i], tb[i], tc[i], lat, gs, gc, bs, hd, dg);
            vectors++;
            if ({gc, gs} !== expv) begin
                miscompares++;
                $display("[TB] FAIL directed_sum[%0d]: got %b_%h expected %b_%h", i, gc, gs, expv[8], expv[7:0]);
            end
            vectors++;
            if (lat !== 8 || bs !== 1'b1 || hd !== 1'b1 || dg !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL directed_timing[%0d]: got lat=%0d busy=%b held=%b done_gone=%b expected 8 1 1 1", i, lat, bs, hd, dg);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] expv;
        int lat;
        logic [7:0] gs;
        logic gc, bs, hd, dg;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            expv = 9'(ra) + 9'(rb) + 9'(rc);
            do_op(ra, rb, rc, lat, gs, gc, bs, hd, dg);
            vectors++;
            if ({gc, gs} !== expv || lat !== 8 || hd !== 1'b1 || dg !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] %h+%h+%b: got %b_%h lat=%0d held=%b done_gone=%b expected %b_%h lat=8",
                         i, ra, rb, rc, gc, gs, lat, hd, dg, expv[8], expv[7:0]);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int k;
        int extra_busy;
        @(negedge clk);
        a = 8'h3C; b = 8'h47; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 3;
        while (k < 20 && !done) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        vectors++;
        if (k !== 8 || sum !== 8'h84 || c_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_inputs: got lat=%0d sum=%h c_out=%b expected lat=8 sum=84 c_out=0", k, sum, c_out);
        end
        extra_busy = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) extra_busy++;
        end
        vectors++;
        if (extra_busy !== 0) begin
            miscompares++;
            $display("[TB] FAIL no_extra_op: got %0d busy cycles expected 0", extra_busy);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, ndone;
        logic [7:0] s1, s2;
        d1 = -1; d2 = -1; ndone = 0; s1 = '0; s2 = '0;
        @(negedge clk);
        a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 12) start = 1'b0;
            if (done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = k; s1 = sum;
                end else if (d2 < 0) begin
                    d2 = k; s2 = sum;
                end
            end
        end
        vectors++;
        if (d1 !== 8 || d2 !== 18 || ndone !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_timing: got done at %0d,%0d count=%0d expected 8,18 count=2", d1, d2, ndone);
        end
        vectors++;
        if (s1 !== 8'h03 || s2 !== 8'h30) begin
            miscompares++;
            $display("[TB] FAIL b2b_sums: got %h,%h expected 03,30", s1, s2);
        end
    endtask

    task automatic test_reset_mid();
        int saw_done;
        int lat;
        logic [7:0] gs;
        logic gc, bs, hd, dg;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        vectors++;
        if (sum !== 8'h30 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got sum=%h busy=%b expected 30 1", sum, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (sum !== 8'h00 || c_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got sum=%h c_out=%b busy=%b done=%b expected 00 0 0 0", sum, c_out, busy, done);
        end
        saw_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        vectors++;
        if (saw_done !== 0) begin
            miscompares++;
            $display("[TB] FAIL aborted_done: got %0d done pulses expected 0", saw_done);
        end
        do_op(8'h05, 8'h03, 1'b0, lat, gs, gc, bs, hd, dg);
        vectors++;
        if (gs !== 8'h08 || gc !== 1'b0 || lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL after_reset: got sum=%h c_out=%b lat=%0d expected 08 0 8", gs, gc, lat);
        end
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] expv;
        for (int i = 0; i < 9; i++) begin
            v = (i == 0) ? 3'b111 : 3'(i - 1);
            expv = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; c1 = v[0]; start1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            a1 = ~v[2]; b1 = ~v[1]; c1 = ~v[0];
            vectors++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL w1_add[%0d]: got busy=%b done=%b expected 1 0", i, busy1, done1);
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (done1 !== 1'b1 || {cout1, sum1} !== expv) begin
                miscompares++;
                $display("[TB] FAIL w1_result[%0d]: got done=%b c_out,sum=%b expected 1 %b", i, done1, {cout1, sum1}, expv);
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL w1_idle[%0d]: got done=%b busy=%b expected 0 0", i, done1, busy1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
